conv_c1w4h4_seq_ctrl: RTL

Sequencer for single-channel 4x4 input, 2x2 kernel, stride-1 convolution with a 3x3 output.
- Accepts weights/bias on a config stream and pixels on an input stream.
- Buffers one full frame, then time-shares one multiply-accumulate unit over all 36 taps.
- Emits the 9 results serially on a valid/ready output stream.
- Sits between the feature-map loader and the next layer; a low-area alternative to the fully parallel conv datapath.

---
 rtl/conv_seq_pkg.sv | 37 +++
 rtl/conv_mac_unit.sv | 45 ++++
 rtl/conv_c1w4h4_seq_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared constants, state encoding and saturation helper for the sequential
// 4x4 / 2x2 convolution controller.
package conv_seq_pkg;

  localparam int DW_DEFAULT   = 8;
  localparam int ACCW_DEFAULT = 2 * DW_DEFAULT + 3;

  localparam int IMG_W  = 4;
  localparam int K_W    = 2;
  localparam int OUT_W  = 3;
  localparam int N_TAPS = 4;
  localparam int N_CFG  = 5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_X  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } state_e;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 32'sd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/conv_mac_unit.sv
// Registered signed multiply-accumulate; load_bias restarts the sum from the
// sign-extended bias instead of the held accumulator.
module conv_mac_unit
  import conv_seq_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int ACCW = ACCW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   load_bias,
  input  logic signed [DW-1:0]   bias,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [ACCW-1:0] acc_next
);

  logic signed [2*DW-1:0] prod_s;
  logic signed [ACCW-1:0] base_s;
  logic signed [ACCW-1:0] acc_r;

  // Next accumulator value, exposed so the caller can register the final sum.
  always_comb begin
    prod_s = a * b;
    if (load_bias) begin
      base_s = ACCW'(bias);
    end else begin
      base_s = acc_r;
    end
    acc_next = base_s + ACCW'(prod_s);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_next;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/conv_c1w4h4_seq_ctrl.sv
// Sequential 4x4 input / 2x2 kernel convolution: buffers a frame, then walks
// 9 positions x 4 taps through one MAC. Define CONV_SEQ_RELU_EN for ReLU output.
module conv_c1w4h4_seq_ctrl
  import conv_seq_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int ACCW = ACCW_DEFAULT
) (
  input  logic                 clk_en,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic signed [DW-1:0] cfg_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_last,
  output logic                 w_loaded,
  output logic                 busy,
  output logic                 done
);

  localparam logic [2:0] IDLE    = S_IDLE;
  localparam logic [2:0] LOAD_W  = S_LOAD_W;
  localparam logic [2:0] LOAD_X  = S_LOAD_X;
  localparam logic [2:0] COMPUTE = S_COMPUTE;
  localparam logic [2:0] DRAIN   = S_DRAIN;

  logic [2:0]           state_r;
  logic [3:0]           cnt_r;
  logic [1:0]           row_r;
  logic [1:0]           col_r;
  logic [1:0]           tap_r;
  logic                 w_loaded_r;
  logic signed [DW-1:0] cfg_r [N_CFG];
  logic signed [DW-1:0] pix_r [IMG_W*IMG_W];

  logic signed [DW-1:0] out_data_r;
  logic                 out_valid_r;
  logic                 out_last_r;
  logic                 done_r;

  logic                   cfg_ready_s;
  logic                   in_ready_s;
  logic                   cfg_fire_s;
  logic                   in_fire_s;
  logic                   out_fire_s;
  logic                   stall_s;
  logic                   mac_en_s;
  logic                   last_pos_s;
  logic [1:0]             rr_s;
  logic [1:0]             cc_s;
  logic signed [DW-1:0]   pix_s;
  logic signed [DW-1:0]   wgt_s;
  logic signed [ACCW-1:0] acc_next_s;
  logic signed [DW-1:0]   sat_s;
  logic signed [DW-1:0]   res_s;

  // Handshake readiness per state; both forced low while reset is held.
  always_comb begin
    cfg_ready_s = 1'b0;
    in_ready_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cfg_ready_s = 1'b1;
        in_ready_s  = w_loaded_r & ~cfg_valid;
      end
      LOAD_W:  cfg_ready_s = 1'b1;
      LOAD_X:  in_ready_s  = 1'b1;
      default: begin
        cfg_ready_s = 1'b0;
        in_ready_s  = 1'b0;
      end
    endcase
    if (rst_n) begin
      cfg_ready_s = 1'b0;
      in_ready_s  = 1'b0;
    end else begin
      cfg_ready_s = cfg_ready_s;
      in_ready_s  = in_ready_s;
    end
  end

  // Tap operand selection and stall decision; a position may only start once
  // the previous result has left the output register.
  always_comb begin
    cfg_fire_s = cfg_valid & cfg_ready_s;
    in_fire_s  = in_valid & in_ready_s;
    out_fire_s = out_valid_r & out_ready;
    stall_s    = (tap_r == 2'd0) & out_valid_r & ~out_ready;
    mac_en_s   = (state_r == COMPUTE) & ~stall_s;
    last_pos_s = (row_r == 2'd2) & (col_r == 2'd2);
    rr_s       = row_r + {1'b0, tap_r[1]};
    cc_s       = col_r + {1'b0, tap_r[0]};
    pix_s      = pix_r[{rr_s, cc_s}];
    wgt_s      = cfg_r[{1'b0, tap_r}];
  end

  conv_mac_unit #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .clk       (clk_en),
    .rst       (rst_n),
    .en        (mac_en_s),
    .load_bias (tap_r == 2'd0),
    .bias      (cfg_r[3'd4]),
    .a         (pix_s),
    .b         (wgt_s),
    .acc_next  (acc_next_s)
  );

  // Result formatting: saturate, optionally rectify.
  always_comb begin
    sat_s = DW'(sat_to(64'(acc_next_s), DW));
`ifdef CONV_SEQ_RELU_EN
    if (sat_s[DW-1]) begin
      res_s = '0;
    end else begin
      res_s = sat_s;
    end
`else
    res_s = sat_s;
`endif
  end

  // Control FSM, stream capture and position/tap walk.
  always_ff @(posedge clk_en) begin
    if (rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      row_r      <= 2'd0;
      col_r      <= 2'd0;
      tap_r      <= 2'd0;
      w_loaded_r <= 1'b0;
      for (int i = 0; i < N_CFG; i++) cfg_r[i] <= '0;
      for (int i = 0; i < IMG_W * IMG_W; i++) pix_r[i] <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg_fire_s) begin
            cfg_r[0]   <= cfg_data;
            cnt_r      <= 4'd1;
            w_loaded_r <= 1'b0;
            state_r    <= LOAD_W;
          end else if (in_fire_s) begin
            pix_r[0] <= in_data;
            cnt_r    <= 4'd1;
            state_r  <= LOAD_X;
          end
        end
        LOAD_W: begin
          if (cfg_fire_s) begin
            cfg_r[cnt_r[2:0]] <= cfg_data;
            if (cnt_r == 4'd4) begin
              cnt_r      <= 4'd0;
              w_loaded_r <= 1'b1;
              state_r    <= IDLE;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        LOAD_X: begin
          if (in_fire_s) begin
            pix_r[cnt_r] <= in_data;
            if (cnt_r == 4'd15) begin
              cnt_r   <= 4'd0;
              row_r   <= 2'd0;
              col_r   <= 2'd0;
              tap_r   <= 2'd0;
              state_r <= COMPUTE;
            end else begin
              cnt_r <= cnt_r + 4'd1;
            end
          end
        end
        COMPUTE: begin
          if (mac_en_s) begin
            tap_r <= tap_r + 2'd1;
            if (tap_r == 2'd3) begin
              if (last_pos_s) begin
                state_r <= DRAIN;
              end else if (col_r == 2'd2) begin
                col_r <= 2'd0;
                row_r <= row_r + 2'd1;
              end else begin
                col_r <= col_r + 2'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (out_fire_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output stream register and completion pulse.
  always_ff @(posedge clk_en) begin
    if (rst_n) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      done_r <= (state_r == DRAIN) & out_fire_s & out_last_r;
      if (mac_en_s && (tap_r == 2'd3)) begin
        out_data_r  <= res_s;
        out_valid_r <= 1'b1;
        out_last_r  <= last_pos_s;
      end else if (out_fire_s) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign cfg_ready = cfg_ready_s;
  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign w_loaded  = w_loaded_r;
  assign busy      = (state_r != IDLE);
  assign done      = done_r;

endmodule
